// File: rtl/latency_addr_responder.sv
// Responder for the softmax control unit: four stage-latency counters returning
// *_latency_cnt_done, plus two wrapping read-address generators for RAM1/RAM2.

// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | cnt=0, done=0, waiting for en
// ST_COUNT  | 1 <= cnt < LAT, done=0
// ST_DONE   | cnt=LAT, done=1, held while en stays high
module latency_counter #(
  parameter int LAT   = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (!en) begin
      // Dropping en aborts from any state; the next enable restarts the full count.
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COUNT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LAT_C) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COUNT;
            done_d  = 1'b0;
          end
        end
        ST_DONE: begin
          cnt_d  = LAT_C;
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign done = done_q;

endmodule

module addr_gen #(
  parameter int TOTAL_VALUES = 5,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(TOTAL_VALUES - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (en) begin
      // >= rather than == so an out-of-range address can never run away.
      if (addr_q >= LAST_C) begin
        addr_d = '0;
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

module latency_addr_responder #(
  parameter int TOTAL_VALUES = 5,
  parameter int ADDR_W       = 10,
  parameter int EXPO_LAT     = 4,
  parameter int ACC_LAT      = 2,
  parameter int RECI_LAT     = 8,
  parameter int MULTI_LAT    = 4,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              expo_latency_cnt_en,
  output logic              expo_latency_cnt_done,
  input  logic              acc_latency_cnt_en,
  output logic              acc_latency_cnt_done,
  input  logic              reci_latency_cnt_en,
  output logic              reci_latency_cnt_done,
  input  logic              multi_latency_cnt_en,
  output logic              multi_latency_cnt_done,
  input  logic              addr_gen1_en,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_wrap,
  input  logic              addr_gen2_en,
  output logic [ADDR_W-1:0] ram2_addr,
  output logic              ram2_wrap
);

  latency_counter #(.LAT(EXPO_LAT), .CNT_W(CNT_W)) u_expo_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (expo_latency_cnt_en),
    .done (expo_latency_cnt_done)
  );

  latency_counter #(.LAT(ACC_LAT), .CNT_W(CNT_W)) u_acc_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_latency_cnt_en),
    .done (acc_latency_cnt_done)
  );

  latency_counter #(.LAT(RECI_LAT), .CNT_W(CNT_W)) u_reci_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (reci_latency_cnt_en),
    .done (reci_latency_cnt_done)
  );

  latency_counter #(.LAT(MULTI_LAT), .CNT_W(CNT_W)) u_multi_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (multi_latency_cnt_en),
    .done (multi_latency_cnt_done)
  );

  addr_gen #(.TOTAL_VALUES(TOTAL_VALUES), .ADDR_W(ADDR_W)) u_addr_gen1 (
    .clk  (clk),
    .rst  (rst),
    .en   (addr_gen1_en),
    .addr (ram1_addr),
    .wrap (ram1_wrap)
  );

  addr_gen #(.TOTAL_VALUES(TOTAL_VALUES), .ADDR_W(ADDR_W)) u_addr_gen2 (
    .clk  (clk),
    .rst  (rst),
    .en   (addr_gen2_en),
    .addr (ram2_addr),
    .wrap (ram2_wrap)
  );

endmodule

// File: tb/tb_latency_addr_responder.sv
// Bench for latency_addr_responder: run-length/modulo reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_latency_addr_responder;

  localparam int TV     = 5;
  localparam int ADDR_W = 10;
  localparam int LAT [4] = '{4, 2, 8, 4};

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        cnt_en;
  logic [3:0]        cnt_done;
  logic              gen1_en, gen2_en;
  logic [ADDR_W-1:0] ram1_addr, ram2_addr;
  logic              ram1_wrap, ram2_wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  latency_addr_responder #(
    .TOTAL_VALUES(TV), .ADDR_W(ADDR_W), .EXPO_LAT(4), .ACC_LAT(2),
    .RECI_LAT(8), .MULTI_LAT(4), .CNT_W(8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .expo_latency_cnt_en    (cnt_en[0]),
    .expo_latency_cnt_done  (cnt_done[0]),
    .acc_latency_cnt_en     (cnt_en[1]),
    .acc_latency_cnt_done   (cnt_done[1]),
    .reci_latency_cnt_en    (cnt_en[2]),
    .reci_latency_cnt_done  (cnt_done[2]),
    .multi_latency_cnt_en   (cnt_en[3]),
    .multi_latency_cnt_done (cnt_done[3]),
    .addr_gen1_en           (gen1_en),
    .ram1_addr              (ram1_addr),
    .ram1_wrap              (ram1_wrap),
    .addr_gen2_en           (gen2_en),
    .ram2_addr              (ram2_addr),
    .ram2_wrap              (ram2_wrap)
  );

  // Model: done = run of consecutive enabled edges reached LAT;
  // addr = enabled edges since reset mod TV; wrap = this edge enabled and landed on 0.
  int run  [4];
  int acnt [2];
  bit awrap[2];
  bit model_valid = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) run[i] = 0;
    for (int i = 0; i < 2; i++) begin acnt[i] = 0; awrap[i] = 1'b0; end
  end

  always @(posedge clk) begin
    logic [1:0] g;
    g = {gen2_en, gen1_en};
    model_valid <= 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rst || !cnt_en[i]) run[i] = 0;
      else if (run[i] < 1000) run[i] = run[i] + 1;
    end
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        acnt[j]  = 0;
        awrap[j] = 1'b0;
      end else if (g[j]) begin
        acnt[j]  = acnt[j] + 1;
        awrap[j] = (acnt[j] % TV) == 0;
      end else begin
        awrap[j] = 1'b0;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      cmp("model expo_done",  int'(cnt_done[0]), int'(run[0] >= LAT[0]));
      cmp("model acc_done",   int'(cnt_done[1]), int'(run[1] >= LAT[1]));
      cmp("model reci_done",  int'(cnt_done[2]), int'(run[2] >= LAT[2]));
      cmp("model multi_done", int'(cnt_done[3]), int'(run[3] >= LAT[3]));
      cmp("model ram1_addr",  int'(ram1_addr),   acnt[0] % TV);
      cmp("model ram1_wrap",  int'(ram1_wrap),   int'(awrap[0]));
      cmp("model ram2_addr",  int'(ram2_addr),   acnt[1] % TV);
      cmp("model ram2_wrap",  int'(ram2_wrap),   int'(awrap[1]));
    end
  end

  task automatic chk_all_zero(input string name);
    cmp(name, int'({cnt_done, ram1_wrap, ram2_wrap}), 0);
    cmp(name, int'(ram1_addr) + int'(ram2_addr), 0);
  endtask

  initial begin
    int exp_a1 [6] = '{1, 2, 3, 4, 0, 1};
    int exp_w1 [6] = '{0, 0, 0, 0, 1, 0};

    rst = 1'b1; cnt_en = 4'hF; gen1_en = 1'b1; gen2_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset outputs");
    end
    rst = 1'b0; cnt_en = 4'h0; gen1_en = 1'b0; gen2_en = 1'b0;
    @(negedge clk);
    chk_all_zero("post-reset outputs");

    cnt_en[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      cmp("expo done early", int'(cnt_done[0]), 0);
    end
    @(negedge clk);
    cmp("expo done at LAT", int'(cnt_done[0]), 1);
    repeat (5) begin
      @(negedge clk);
      cmp("expo done sticky", int'(cnt_done[0]), 1);
    end
    cnt_en[0] = 1'b0;
    @(negedge clk);
    cmp("expo done fall", int'(cnt_done[0]), 0);

    cnt_en[2] = 1'b1;
    repeat (5) @(negedge clk);
    cnt_en[2] = 1'b0;
    @(negedge clk);
    cnt_en[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      cmp("reci restart early", int'(cnt_done[2]), 0);
    end
    @(negedge clk);
    cmp("reci restart done", int'(cnt_done[2]), 1);
    cnt_en[2] = 1'b0;
    @(negedge clk);

    cnt_en[1] = 1'b1; cnt_en[3] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      cmp("parallel acc",   int'(cnt_done[1]), int'(e >= 2));
      cmp("parallel multi", int'(cnt_done[3]), int'(e >= 4));
    end
    cnt_en[1] = 1'b0; cnt_en[3] = 1'b0;
    @(negedge clk);

    gen1_en = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      cmp("ram1 addr seq", int'(ram1_addr), exp_a1[e]);
      cmp("ram1 wrap seq", int'(ram1_wrap), exp_w1[e]);
    end
    gen1_en = 1'b0;
    @(negedge clk);
    cmp("ram1 addr hold", int'(ram1_addr), 1);
    cmp("ram1 wrap clear", int'(ram1_wrap), 0);

    gen2_en = 1'b1; @(negedge clk);
    cmp("ram2 edge1", int'(ram2_addr), 1);
    gen2_en = 1'b0; @(negedge clk);
    cmp("ram2 hold", int'(ram2_addr), 1);
    gen2_en = 1'b1; @(negedge clk);
    cmp("ram2 edge3", int'(ram2_addr), 2);
    @(negedge clk);
    cmp("ram2 edge4", int'(ram2_addr), 3);
    gen2_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    cmp("ram2 reset addr", int'(ram2_addr), 0);
    cmp("ram2 reset wrap", int'(ram2_wrap), 0);
    cmp("ram1 reset addr", int'(ram1_addr), 0);
    rst = 1'b0;

    cnt_en[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("expo reset mid-count", int'(cnt_done[0]), 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      cmp("expo after reset early", int'(cnt_done[0]), 0);
    end
    @(negedge clk);
    cmp("expo after reset done", int'(cnt_done[0]), 1);
    cnt_en[0] = 1'b0;

    gen1_en = 1'b1; gen2_en = 1'b1; cnt_en = 4'hF;
    repeat (12) @(negedge clk);
    cnt_en = 4'h0; gen1_en = 1'b0; gen2_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
